// File: rtl/spi_flash_arbiter_pkg.sv
// Shared types and constants for the two-requester SPI flash read arbiter.
package spi_flash_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    END
  } state_e;

  localparam logic [7:0] READ_CMD_DEF = 8'h03;
  localparam logic       OWNER_VID    = 1'b0;
  localparam logic       OWNER_AUD    = 1'b1;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI bit engine: clock divider, SCLK generation, 8-bit TX/RX shifting
// and per-byte strobes for the arbiter FSM.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] start_byte_i,
  input  logic       run_i,
  input  logic [7:0] next_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       rx_strobe_o,
  output logic [7:0] rx_byte_o,
  output logic       byte_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             sclk_q;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic             tick;

  assign tick        = run_i && (div_q == DIV_W'(CLK_DIV - 1));
  assign rx_strobe_o = tick && !sclk_q && (bit_q == 3'd7);
  assign byte_done_o = tick && sclk_q && (bit_q == 3'd7);
  // Includes the bit being sampled on this tick so the byte is whole at the strobe.
  assign rx_byte_o   = {rx_q[6:0], miso_i};
  assign sclk_o      = sclk_q;
  assign mosi_o      = tx_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= 3'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else if (start_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= 3'd0;
      tx_q   <= start_byte_i;
    end else if (run_i) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick && !sclk_q) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], miso_i};
      end else if (tick) begin
        sclk_q <= 1'b0;
        bit_q  <= bit_q + 1'b1;
        tx_q   <= (bit_q == 3'd7) ? next_byte_i : {tx_q[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the SPI flash between video and audio fetchers, issues READ with a
// 24-bit address and streams the burst back tagged with its owner.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter int         LEN_W    = 6,
  parameter logic [7:0] READ_CMD = READ_CMD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vid_req,
  input  logic [23:0]      vid_addr,
  input  logic [LEN_W-1:0] vid_len,
  output logic             vid_done,
  input  logic             aud_req,
  input  logic [23:0]      aud_addr,
  input  logic [LEN_W-1:0] aud_len,
  output logic             aud_done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_owner,
  output logic             busy,
  output logic             SCLK,
  output logic             SSEL,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int CNT_W = (LEN_W < 2) ? 2 : LEN_W;
  localparam int END_W = $clog2(2 * CLK_DIV);

  state_e           state_q;
  logic             owner_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] byte_q;
  logic [END_W-1:0] end_q;
  logic             busy_q, ssel_q, rd_valid_q, rd_owner_q, vid_done_q, aud_done_q;
  logic [7:0]       rd_data_q;

  logic       grant, run, rx_strobe, byte_done;
  logic [7:0] rx_byte, next_byte;

  assign grant = (state_q == IDLE) && (aud_req || vid_req);
  assign run   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

  // Byte to load when the current one finishes shifting; zero once in DATA.
  always_comb begin
    next_byte = 8'h00;
    if (state_q == CMD)
      next_byte = addr_q[23:16];
    else if ((state_q == ADDR) && (byte_q == CNT_W'(0)))
      next_byte = addr_q[15:8];
    else if ((state_q == ADDR) && (byte_q == CNT_W'(1)))
      next_byte = addr_q[7:0];
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (grant),
    .start_byte_i(READ_CMD),
    .run_i       (run),
    .next_byte_i (next_byte),
    .miso_i      (MISO),
    .sclk_o      (SCLK),
    .mosi_o      (MOSI),
    .rx_strobe_o (rx_strobe),
    .rx_byte_o   (rx_byte),
    .byte_done_o (byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_VID;
      addr_q     <= 24'h0;
      len_q      <= '0;
      byte_q     <= '0;
      end_q      <= '0;
      busy_q     <= 1'b0;
      ssel_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWNER_VID;
      rd_data_q  <= 8'h00;
      vid_done_q <= 1'b0;
      aud_done_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      vid_done_q <= 1'b0;
      aud_done_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          // Audio has fixed priority; the grant is held until END completes.
          owner_q <= aud_req ? OWNER_AUD : OWNER_VID;
          addr_q  <= aud_req ? aud_addr : vid_addr;
          len_q   <= aud_req ? aud_len : vid_len;
          busy_q  <= 1'b1;
          ssel_q  <= 1'b0;
          state_q <= CMD;
        end
        CMD: if (byte_done) begin
          byte_q  <= '0;
          state_q <= ADDR;
        end
        ADDR: if (byte_done) begin
          if (byte_q == CNT_W'(2)) begin
            byte_q  <= '0;
            state_q <= DATA;
          end else begin
            byte_q <= byte_q + 1'b1;
          end
        end
        DATA: begin
          if (rx_strobe) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rx_byte;
            rd_owner_q <= owner_q;
          end
          if (byte_done) begin
            if (byte_q == CNT_W'(len_q)) begin
              state_q    <= END;
              ssel_q     <= 1'b1;
              end_q      <= '0;
              vid_done_q <= (owner_q == OWNER_VID);
              aud_done_q <= (owner_q == OWNER_AUD);
            end else begin
              byte_q <= byte_q + 1'b1;
            end
          end
        end
        END: begin
          if (end_q == END_W'(2 * CLK_DIV - 1)) begin
            end_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            end_q <= end_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign SSEL     = ssel_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_owner = rd_owner_q;
  assign vid_done = vid_done_q;
  assign aud_done = aud_done_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: two instances (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural mode-0 flash model; received bytes are checked against a scoreboard queue.
module tb_spi_flash_arbiter;

  localparam int LEN_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             vid_req  [2];
  logic [23:0]      vid_addr [2];
  logic [LEN_W-1:0] vid_len  [2];
  logic             aud_req  [2];
  logic [23:0]      aud_addr [2];
  logic [LEN_W-1:0] aud_len  [2];
  logic             vid_done [2];
  logic             aud_done [2];
  logic [7:0]       rd_data  [2];
  logic             rd_valid [2];
  logic             rd_owner [2];
  logic             busy     [2];
  logic             sclk     [2];
  logic             ssel     [2];
  logic             mosi     [2];
  logic [7:0]       flash_data [2][64];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int CD = (gi == 0) ? 2 : 1;
    logic        miso = 1'b0;
    logic        sclk_prev = 1'b0;
    logic [31:0] cap = 32'h0;
    logic [7:0]  cur;
    int nbits = 0, dbit = 0, since_rise = 0, gap_err = 0, mosi_err = 0;

    spi_flash_arbiter #(.CLK_DIV(CD), .LEN_W(LEN_W), .READ_CMD(8'h03)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req[gi]), .vid_addr(vid_addr[gi]), .vid_len(vid_len[gi]), .vid_done(vid_done[gi]),
      .aud_req(aud_req[gi]), .aud_addr(aud_addr[gi]), .aud_len(aud_len[gi]), .aud_done(aud_done[gi]),
      .rd_data(rd_data[gi]), .rd_valid(rd_valid[gi]), .rd_owner(rd_owner[gi]), .busy(busy[gi]),
      .SCLK(sclk[gi]), .SSEL(ssel[gi]), .MOSI(mosi[gi]), .MISO(miso)
    );

    // Flash: capture command+address on rising SCLK, drive data after each falling SCLK.
    always @(negedge clk) begin
      if (ssel[gi]) begin
        nbits = 0;
        dbit  = 0;
      end else if (sclk[gi] && !sclk_prev) begin
        if (nbits > 0 && since_rise != 2 * CD) gap_err++;
        if (nbits < 32) cap = {cap[30:0], mosi[gi]};
        else if (mosi[gi]) mosi_err++;
        nbits++;
        since_rise = 0;
      end else if (!sclk[gi] && sclk_prev && nbits >= 32 && dbit < 512) begin
        cur  = flash_data[gi][dbit / 8];
        miso = cur[7 - (dbit % 8)];
        dbit++;
      end
      since_rise++;
      sclk_prev = sclk[gi];
    end
  end

  typedef struct {
    logic       owner;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int               inst;
    bit               aud;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       d0;
    logic [7:0]       step;
  } vec_t;

  int tests = 0, fails = 0;
  int g2e, hold, nrd, ndone, overlap = 0;
  bit done_aud;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cap_of(input int i);
    return (i == 0) ? g_inst[0].cap : g_inst[1].cap;
  endfunction

  task automatic issue(input int i, input bit aud, input logic [23:0] addr,
                       input logic [LEN_W-1:0] len, input logic [7:0] d0, input logic [7:0] step);
    logic [7:0] b;
    for (int k = 0; k <= int'(len); k++) begin
      b = d0 + 8'(k) * step;
      flash_data[i][k] = b;
      exp_q.push_back('{aud, b});
    end
    if (aud) begin
      aud_addr[i] = addr; aud_len[i] = len; aud_req[i] = 1'b1;
    end else begin
      vid_addr[i] = addr; vid_len[i] = len; vid_req[i] = 1'b1;
    end
  endtask

  // Runs until the burst's done pulse and the return to IDLE (or stop_rd bytes seen).
  task automatic run_until(input int i, input int stop_rd, input int budget);
    bit granted = 0, ended = 0, seen_done = 0, finished = 0;
    exp_t e;
    g2e = 0; hold = 0; nrd = 0; ndone = 0; done_aud = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      if (!granted) granted = busy[i];
      else if (!ended) begin
        g2e++;
        ended = ssel[i];
      end
      if (ended && busy[i] && ssel[i]) hold++;
      if (rd_valid[i]) begin
        nrd++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_extra: inst%0d got byte 0x%02h, expected no byte", i, rd_data[i]);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data[i], e.data);
          chk("rd_owner", rd_owner[i], e.owner);
        end
        if (stop_rd > 0 && nrd == stop_rd) finished = 1;
      end
      if (vid_done[i] || aud_done[i]) begin
        ndone++;
        done_aud  = aud_done[i];
        seen_done = 1;
        if (rd_valid[i]) overlap++;
        if (aud_done[i]) aud_req[i] = 1'b0;
        else vid_req[i] = 1'b0;
      end
      if (seen_done && !busy[i]) finished = 1;
    end
    if (!finished) begin
      tests++; fails++;
      $display("FAIL timeout: inst%0d ran %0d cycles, expected done and idle", i, budget);
    end
  endtask

  vec_t vecs[5];
  int   dn, cd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      vid_req[i] = 0; vid_addr[i] = 0; vid_len[i] = 0;
      aud_req[i] = 0; aud_addr[i] = 0; aud_len[i] = 0;
    end
    vecs[0] = '{0, 1'b0, 24'h012345, 6'd0,  8'hA5, 8'h00};
    vecs[1] = '{0, 1'b1, 24'hFFFFFF, 6'd3,  8'h80, 8'h11};
    vecs[2] = '{0, 1'b0, 24'h000000, 6'd1,  8'hFF, 8'h01};
    vecs[3] = '{0, 1'b1, 24'h000100, 6'd63, 8'h00, 8'h01};
    vecs[4] = '{1, 1'b0, 24'hABCDEF, 6'd2,  8'h5A, 8'h69};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_state", {ssel[i], sclk[i], mosi[i], rd_data[i], rd_valid[i], rd_owner[i],
                          vid_done[i], aud_done[i], busy[i]}, 32'h8000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[t]) begin
      cd = (vecs[t].inst == 0) ? 2 : 1;
      issue(vecs[t].inst, vecs[t].aud, vecs[t].addr, vecs[t].len, vecs[t].d0, vecs[t].step);
      run_until(vecs[t].inst, 0, 4000);
      chk("cmd_addr", cap_of(vecs[t].inst), {8'h03, vecs[t].addr});
      chk("byte_count", nrd, int'(vecs[t].len) + 1);
      chk("done_count", ndone, 1);
      chk("done_owner", done_aud, vecs[t].aud);
      chk("grant_to_end", g2e, (32 + 8 * (int'(vecs[t].len) + 1)) * 2 * cd);
      chk("ssel_hold", hold, 2 * cd);
      $display("[TB] txn %0d inst%0d %s addr=%06h len=%0d bytes=%0d g2e=%0d", t, vecs[t].inst,
               vecs[t].aud ? "aud" : "vid", vecs[t].addr, vecs[t].len, nrd, g2e);
      repeat (2) @(negedge clk);
    end

    // Both requests in the same cycle: audio first, video right after END.
    issue(0, 1'b1, 24'h000100, 6'd1, 8'h11, 8'h11);
    issue(0, 1'b0, 24'h004000, 6'd0, 8'h11, 8'h00);
    run_until(0, 0, 4000);
    chk("simul_first_owner", done_aud, 1'b1);
    chk("simul_first_addr", cap_of(0), 32'h03000100);
    chk("simul_first_bytes", nrd, 2);
    run_until(0, 0, 4000);
    chk("simul_second_owner", done_aud, 1'b0);
    chk("simul_second_addr", cap_of(0), 32'h03004000);
    chk("simul_second_bytes", nrd, 1);
    $display("[TB] txn simul aud then vid, last bytes=%0d", nrd);
    repeat (2) @(negedge clk);

    // Video request dropped while the address is being shifted out.
    issue(0, 1'b0, 24'h0ABCDE, 6'd2, 8'h31, 8'h10);
    repeat (50) @(negedge clk);
    chk("busy_at_drop", busy[0], 1'b1);
    vid_req[0] = 1'b0;
    run_until(0, 0, 4000);
    chk("drop_bytes", nrd, 3);
    chk("drop_done", ndone, 1);
    repeat (6) @(negedge clk);
    chk("drop_idle", {busy[0], ssel[0]}, 2'b01);
    $display("[TB] txn drop vid addr=0abcde bytes=%0d", nrd);

    // Reset after 3 of 8 bytes, then a fresh read.
    issue(0, 1'b1, 24'h200000, 6'd7, 8'h40, 8'h03);
    run_until(0, 3, 4000);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ssel[0], sclk[0], busy[0], rd_valid[0], aud_done[0]}, 5'b10000);
    aud_req[0] = 1'b0;
    exp_q.delete();
    dn = 0;
    repeat (4) begin @(negedge clk); if (aud_done[0] || vid_done[0]) dn++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (aud_done[0] || vid_done[0]) dn++; end
    chk("no_done_after_rst", dn, 0);
    issue(0, 1'b0, 24'h000042, 6'd0, 8'h99, 8'h00);
    run_until(0, 0, 4000);
    chk("post_rst_cmd", cap_of(0), 32'h03000042);
    chk("post_rst_bytes", nrd, 1);
    $display("[TB] txn reset mid-burst, fresh read bytes=%0d", nrd);

    chk("sclk_gap_div2", g_inst[0].gap_err, 0);
    chk("sclk_gap_div1", g_inst[1].gap_err, 0);
    chk("mosi_data_div2", g_inst[0].mosi_err, 0);
    chk("mosi_data_div1", g_inst[1].mosi_err, 0);
    chk("rd_done_overlap", overlap, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
